// File: rtl/ysyx_22050550_ifetch_pkg.sv
// ysyx_22050550_ifetch_pkg: shared widths, reset PC and fetch FSM encoding
package ysyx_22050550_ifetch_pkg;
  localparam int PC_W = 64;
  localparam int INST_W = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  typedef enum logic {FETCH, FLUSH} state_t;
endpackage

// File: rtl/ysyx_22050550_ifq.sv
// ysyx_22050550_ifq: power-of-two synchronous FIFO with flush, count and head output
module ysyx_22050550_ifq #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_pop;
  assign do_pop = pop & (count != '0);
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ysyx_22050550_ifetch.sv
// ysyx_22050550_ifetch: credit-limited in-order instruction fetch with redirect flush
module ysyx_22050550_ifetch #(
  parameter int PC_W = ysyx_22050550_ifetch_pkg::PC_W,
  parameter int INST_W = ysyx_22050550_ifetch_pkg::INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(ysyx_22050550_ifetch_pkg::RESET_PC),
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst
);
  import ysyx_22050550_ifetch_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt, inflight_pc;
  logic [CW-1:0] out_cnt, out_nxt, occ, inflight_cnt;
  logic [PC_W+INST_W-1:0] head;
  logic fetching, req_fire, rsp_ok, id_fire;
  assign fetching = state == FETCH;
  assign id_fire = id_valid & id_ready;
  // A head pop this cycle frees a slot, so DEPTH=2 sustains one fetch per cycle at 1-cycle latency
  assign imem_req_valid = rst & fetching & fetch_en &
                          ({1'b0, out_cnt} + {1'b0, occ} < (CW+1)'(DEPTH) + (CW+1)'(id_fire));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_ok = imem_rsp_valid & (out_cnt != '0);
  assign id_valid = occ != '0;
  assign {id_pc, id_inst} = id_valid ? head : '0;
  // In FLUSH out_cnt doubles as the drop count: every response there is discarded
  always_comb begin
    out_nxt = out_cnt + CW'(req_fire) - CW'(rsp_ok);
    fetch_pc_nxt = redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} :
                   req_fire ? fetch_pc + PC_W'(4) : fetch_pc;
    state_nxt = (out_nxt != '0 && (redirect_valid || !fetching)) ? FLUSH : FETCH;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      out_cnt <= '0;
    end else begin
      state <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      out_cnt <= out_nxt;
    end
  ysyx_22050550_ifq #(.W(PC_W), .DEPTH(DEPTH)) u_pcq (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(req_fire),
    .pop(rsp_ok & fetching),
    .din(fetch_pc),
    .dout(inflight_pc),
    .count(inflight_cnt)
  );
  ysyx_22050550_ifq #(.W(PC_W+INST_W), .DEPTH(DEPTH)) u_iq (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(rsp_ok & fetching),
    .pop(id_fire),
    .din({inflight_pc, imem_rsp_data}),
    .dout(head),
    .count(occ)
  );
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && out_cnt == '0));
  a_pcq_tracks: assert property (@(posedge clk) disable iff (!rst) !fetching || inflight_cnt == out_cnt);
endmodule

// File: tb/tb_ysyx_22050550_ifetch.sv
// tb_ysyx_22050550_ifetch: directed scoreboard bench with an in-order latency memory model
module tb_ysyx_22050550_ifetch;
  typedef struct packed {logic [63:0] pc; logic [31:0] inst;} exp_t;
  typedef struct packed {logic [63:0] addr; int due;} req_t;
  logic clk = 0, rst = 0, fetch_en = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0, id_valid, id_ready = 0;
  logic [63:0] imem_req_addr, redirect_pc = '0, id_pc;
  logic [31:0] imem_rsp_data = '0, id_inst;
  int n_cmp = 0, n_err = 0, cyc = 0, lat = 1, nfire = 0;
  bit rnd = 0, prev_stall = 0, got;
  logic [63:0] prev_addr = '0, mpc = 64'h8000_0000;
  exp_t sb[$];
  req_t pend[$];

  ysyx_22050550_ifetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] minst(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    imem_req_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rsp_valid = pend.size() > 0 && pend[0].due <= cyc;
    imem_rsp_data = '0;
    if (imem_rsp_valid) imem_rsp_data = minst(pend[0].addr);
    #1;
    if (prev_stall && fetch_en && rst) begin
      chk("hold_valid", 64'(imem_req_valid), 1);
      chk("hold_addr", imem_req_addr, prev_addr);
    end
  endtask

  task automatic adv();
    exp_t e;
    logic rs;
    if (id_valid && id_ready) begin
      e = '1;
      if (sb.size() > 0) e = sb.pop_front();
      chk("id_pc", id_pc, e.pc);
      chk("id_inst", 64'(id_inst), 64'(e.inst));
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, mpc);
      sb.push_back('{pc: mpc, inst: minst(mpc)});
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
      mpc += 4;
      nfire++;
    end
    if (redirect_valid) begin
      sb.delete();
      mpc = {redirect_pc[63:2], 2'b00};
    end
    prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
    prev_addr = imem_req_addr;
    rs = imem_rsp_valid;
    @(posedge clk);
    cyc++;
    if (rs) pend.delete(0);
    @(negedge clk);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      drive();
      adv();
    end
  endtask

  task automatic drain();
    fetch_en = 0;
    id_ready = 1;
    for (int i = 0; i < 40 && (id_valid || pend.size() > 0); i++) tick();
    chk("drain", 64'(id_valid || pend.size() != 0), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 0);
    chk("rst_id_valid", 64'(id_valid), 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_inst", 64'(id_inst), 0);
    chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
    @(negedge clk);
    rst = 1;
    id_ready = 1;
    for (int k = 0; k < 6; k++) begin
      drive();
      chk("t1_req_valid", 64'(imem_req_valid), 1);
      chk("t1_id_valid", 64'(id_valid), 64'(k >= 2));
      if (k >= 2) chk("t1_id_pc", id_pc, 64'h8000_0000 + 64'(4 * (k - 2)));
      adv();
    end
    tick(10);
    drain();
    fetch_en = 1;
    id_ready = 0;
    nfire = 0;
    tick(8);
    drive();
    chk("t2_nreq", 64'(nfire), 2);
    chk("t2_req_stopped", 64'(imem_req_valid), 0);
    chk("t2_id_valid", 64'(id_valid), 1);
    adv();
    id_ready = 1;
    tick(12);
    drain();
    lat = 3;
    fetch_en = 1;
    nfire = 0;
    tick(2);
    chk("t3_nreq", 64'(nfire), 2);
    redirect_valid = 1;
    redirect_pc = 64'h8000_1002;
    drive();
    chk("t3_rdr_req_valid", 64'(imem_req_valid), 0);
    adv();
    redirect_valid = 0;
    for (int i = 0; i < 10 && pend.size() > 0; i++) begin
      drive();
      chk("t3_flush_id_valid", 64'(id_valid), 0);
      chk("t3_flush_req_valid", 64'(imem_req_valid), 0);
      adv();
    end
    chk("t3_drained", 64'(pend.size()), 0);
    drive();
    chk("t3_next_valid", 64'(imem_req_valid), 1);
    chk("t3_next_addr", imem_req_addr, 64'h8000_1000);
    adv();
    lat = 1;
    tick(6);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      drive();
      if (imem_req_valid && imem_req_ready && imem_rsp_valid) begin
        redirect_valid = 1;
        redirect_pc = 64'h8000_2000;
        got = 1;
      end
      adv();
      redirect_valid = 0;
    end
    chk("t4_hit", 64'(got), 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      drive();
      if (id_valid) begin
        chk("t4_first_pc", id_pc, 64'h8000_2000);
        got = 1;
      end
      adv();
    end
    chk("t4_got", 64'(got), 1);
    tick(4);
    drain();
    redirect_valid = 1;
    redirect_pc = 64'h8000_3007;
    tick();
    redirect_valid = 0;
    fetch_en = 1;
    drive();
    chk("t4b_valid", 64'(imem_req_valid), 1);
    chk("t4b_addr", imem_req_addr, 64'h8000_3004);
    adv();
    lat = 3;
    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rnd = 0;
    lat = 1;
    drain();
    fetch_en = 1;
    id_ready = 0;
    tick(6);
    chk("t6_pre_id_valid", 64'(id_valid), 1);
    rst = 0;
    #1;
    chk("t6_rst_id_valid", 64'(id_valid), 0);
    chk("t6_rst_id_pc", id_pc, 0);
    chk("t6_rst_req_valid", 64'(imem_req_valid), 0);
    sb.delete();
    pend.delete();
    mpc = 64'h8000_0000;
    prev_stall = 0;
    @(negedge clk);
    tick(2);
    rst = 1;
    id_ready = 1;
    drive();
    chk("t6_restart_valid", 64'(imem_req_valid), 1);
    chk("t6_restart_addr", imem_req_addr, 64'h8000_0000);
    adv();
    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
